// File: rtl/serial_adder8bit_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding and default width.
package serial_adder8bit_pkg;

  // Default operand / sum width in bits (must be at least 2).
  localparam int DEFAULT_WIDTH = 8;

  // FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Bit counter width: wide enough to hold WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder8bit_if.sv
// Start/busy/done handshake plus operand and result buses of the serial adder.
interface serial_adder8bit_if
  import serial_adder8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             busy;
  logic             done;

  // Requester side: issues operands, observes results.
  modport master (
    output start, A, B, Cin,
    input  S, Cout, busy, done
  );

  // Adder side: accepts operands, produces results.
  modport slave (
    input  start, A, B, Cin,
    output S, Cout, busy, done
  );

endinterface

// File: rtl/serial_adder8bit_full_adder.sv
// Single-bit full adder cell; the bit-cell dual of full_subtractor.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder8bit.sv
// Bit-serial adder: one full-adder cell and a carry flop process the
// operands LSB first, one bit per clock, under a start/busy/done handshake.
module serial_adder8bit
  import serial_adder8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  serial_adder8bit_if.slave bus
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_n;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0] s_r;
  logic             carry_r;
  logic             cout_r;
  logic [CW-1:0]    cnt_r;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;
  logic             busy_s;
  logic             done_s;

  // The one shared bit cell: current LSBs plus the running carry.
  full_adder u_full_adder (
    .a    (opa_r[0]),
    .b    (opb_r[0]),
    .cin  (carry_r),
    .s    (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Accumulator after this bit: new sum bit enters at the MSB end.
  always_comb begin
    acc_next_s = {fa_sum_s, acc_r[WIDTH-1:1]};
  end

  // Qualify load (start accepted in IDLE or DONE), shift step and final bit.
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    case (state_r)
      ST_IDLE: load_s = bus.start;
      ST_DONE: load_s = bus.start;
      ST_RUN:  step_s = 1'b1;
      default: begin
        load_s = 1'b0;
        step_s = 1'b0;
      end
    endcase
    last_s = step_s && (cnt_r == LAST_CNT);
  end

  // State register; reset takes priority over any start request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; start is ignored while RUN is in progress.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_n = ST_RUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_n = ST_RUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_RUN:  busy_s = 1'b1;
      ST_DONE: done_s = 1'b1;
      ST_IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand shift registers, carry flop, accumulator and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_r   <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else if (load_s) begin
      opa_r   <= bus.A;
      opb_r   <= bus.B;
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= bus.Cin;
      cnt_r   <= {CW{1'b0}};
    end else if (step_s) begin
      opa_r   <= {1'b0, opa_r[WIDTH-1:1]};
      opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
      acc_r   <= acc_next_s;
      carry_r <= fa_cout_s;
      cnt_r   <= cnt_r + CW'(1);
    end
  end

  // Result registers: updated only on the final bit, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r    <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
    end else if (last_s) begin
      s_r    <= acc_next_s;
      cout_r <= fa_cout_s;
    end
  end

  // Drive the interface from registers and state decode.
  assign bus.S    = s_r;
  assign bus.Cout = cout_r;
  assign bus.busy = busy_s;
  assign bus.done = done_s;

endmodule

// File: tb/tb_serial_adder8bit.sv
// Directed self-checking bench for serial_adder8bit with a result scoreboard.
module tb_serial_adder8bit;

  logic clk = 1'b0;
  logic rst;

  serial_adder8bit_if #(.WIDTH(8)) bus ();

  serial_adder8bit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  int edge_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int acc_edge;
  int busy_base;
  int done_base;
  int first_done;

  // Rising-edge counter used for latency measurement.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Count busy and done cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.busy) busy_cnt <= busy_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present operands with start for one edge and record the expected sum.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] e;
    e = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    exp_q.push_back(e);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    step(1);
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    bus.Cin   = ~cin;
    acc_edge  = edge_cnt;
    busy_base = busy_cnt;
    done_base = done_cnt;
  endtask

  // Wait (bounded) for done, then check latency, busy length and result.
  task automatic wait_done(input string tag);
    int guard;
    logic [8:0] e;
    guard = 0;
    while (!bus.done && guard < 40) begin
      step(1);
      guard++;
    end
    chk({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_latency"}, edge_cnt - acc_edge + 1, 32'd9);
    chk({tag, "_busy_cycles"}, busy_cnt - busy_base, 32'd8);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = 9'h1FF;
    end
    chk({tag, "_sum"}, {23'd0, bus.Cout, bus.S}, {23'd0, e});
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    bus.Cin   = 1'b0;
    step(3);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_S", {24'd0, bus.S}, 32'd0);
    chk("rst_Cout", {31'd0, bus.Cout}, 32'd0);
    rst = 1'b0;
    step(2);

    // Basic operation with single done pulse.
    start_op(8'h0F, 8'h01, 1'b0);
    chk("op1_busy_after_accept", {31'd0, bus.busy}, 32'd1);
    wait_done("op1");
    step(5);
    chk("op1_single_done", done_cnt - done_base, 32'd1);

    // Carry-out cases; result must hold through the next RUN.
    start_op(8'hFF, 8'h01, 1'b0);
    step(4);
    chk("op2_hold_during_run", {23'd0, bus.Cout, bus.S}, 32'h010);
    wait_done("op2");
    step(1);
    start_op(8'hAA, 8'h55, 1'b1);
    wait_done("op3");
    step(1);
    start_op(8'h00, 8'h00, 1'b1);
    wait_done("op4");

    // Result stays stable across 20 idle cycles.
    begin
      int unstable;
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
        step(1);
        if (bus.S !== 8'h01 || bus.Cout !== 1'b0) unstable++;
      end
      chk("idle_hold_S_Cout", unstable, 32'd0);
      chk("idle_no_extra_done", done_cnt - done_base, 32'd1);
    end

    // Start during RUN is ignored.
    start_op(8'h12, 8'h34, 1'b0);
    step(2);
    bus.start = 1'b1;
    bus.A     = 8'hFF;
    bus.B     = 8'hFF;
    bus.Cin   = 1'b1;
    step(1);
    bus.start = 1'b0;
    wait_done("midrun");
    step(12);
    chk("midrun_single_done", done_cnt - done_base, 32'd1);
    chk("midrun_idle_after", {31'd0, bus.busy}, 32'd0);

    // Back-to-back start in the DONE cycle.
    start_op(8'h01, 8'h02, 1'b0);
    wait_done("b2b_first");
    first_done = edge_cnt;
    start_op(8'h80, 8'h80, 1'b0);
    chk("b2b_busy_next", {31'd0, bus.busy}, 32'd1);
    wait_done("b2b_second");
    chk("b2b_done_spacing", edge_cnt - first_done, 32'd9);
    step(3);

    // Reset on the 4th RUN cycle aborts without a done pulse.
    start_op(8'hF0, 8'h0F, 1'b0);
    step(3);
    chk("abort_in_run", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_S", {24'd0, bus.S}, 32'd0);
    chk("abort_Cout", {31'd0, bus.Cout}, 32'd0);
    begin
      int d0;
      d0 = done_cnt;
      step(15);
      chk("abort_no_done", done_cnt - d0, 32'd0);
    end
    start_op(8'hF0, 8'h0F, 1'b0);
    wait_done("after_abort");
    step(2);

    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder8bit.md
Name: serial_adder8bit

Overview:
- Bit-serial 8-bit adder with carry-in; the additive counterpart of the team's ripple subtractor.
- Processes one bit per clock, LSB first, through a single full-adder cell and a registered carry.
- Uses a start/busy/done handshake so small datapaths can trade area for latency.
- Results are held until the next operation completes or reset.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be at least 2. The counter width is clog2(WIDTH)+1.

Ports:
- clk   input   1      rising-edge clock, the block's only clock
- rst   input   1      synchronous, active-high reset
- start input   1      request a new addition; sampled on the rising edge
- A     input   WIDTH  augend; captured on the accepted start edge
- B     input   WIDTH  addend; captured on the accepted start edge
- Cin   input   1      carry-in; captured on the accepted start edge
- S     output  WIDTH  sum; registered and held between operations
- Cout  output  1      carry-out; registered and held
- busy  output  1      high while bits are being processed (state RUN)
- done  output  1      one-cycle pulse: S and Cout are valid and newly updated

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it takes effect only on a rising edge of clk.
- Reset values: state=IDLE, S=0, Cout=0, busy=0, done=0. The shift registers, carry flop and counter are also cleared to 0.
- States: IDLE, RUN and DONE, with the encoding defined in the package.
- IDLE:
  - start=1 on an edge loads A into opa, B into opb and Cin into the carry flop.
  - The same edge clears the accumulator and bit counter and moves to RUN.
  - start=0 leaves the block in IDLE.
- RUN, on each edge:
  - The full-adder cell takes opa[0], opb[0] and carry.
  - Its sum bit shifts into acc at the MSB end, and acc shifts right.
  - opa and opb shift right, filling with 0.
  - The cell's carry-out is written to the carry flop, and the counter increments.
  - On the edge where counter == WIDTH-1, after the WIDTH-th bit: S <= final acc value, Cout <= final carry, and the state moves to DONE.
- DONE lasts exactly one cycle, with done=1:
  - start=1 behaves exactly as in IDLE (back-to-back operation), and the next state is RUN.
  - Otherwise the next state is IDLE.
- Latency: counting the edge that accepts start as edge 1, S and Cout update on edge WIDTH+1. done is high during the cycle following edge WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- Output decoding: busy = (state==RUN) and done = (state==DONE). Both are decoded from registered state, so there is no combinational path from any input.
- Start during RUN: ignored. Operands are not re-captured, and the running operation completes unaffected.
- Input changes outside the capture edge: A, B and Cin are don't-care on all other edges.
- Hold: S and Cout keep their last value until the next DONE transition or reset. They do not change during RUN.
- Arithmetic: {Cout,S} = A + B + Cin, unsigned modulo 2^(WIDTH+1). No overflow flag.
- Reset priority: rst wins over start on the same edge.
  - Reset mid-RUN aborts the operation.
  - On the next cycle: busy=0, done=0, S=0, Cout=0.
  - No done pulse is ever produced for an aborted operation.

Decomposition:
- Shared package holds:
  - state localparams ST_IDLE=2'd0, ST_RUN=2'd1 and ST_DONE=2'd2;
  - the default WIDTH constant.
- One natural sub-module: full_adder (a, b, cin -> s, cout), purely combinational. It is instantiated once and is the bit-cell dual of the existing full_subtractor.
- The top holds the FSM, counter, operand shift registers, carry flop and result registers.

Test Plan:
- After rst, drive start with A=8'h0F, B=8'h01, Cin=0. Required:
  - busy=1 for 8 cycles;
  - done pulses exactly once, 9 edges after start (start edge counts as edge 1);
  - S=8'h10, Cout=0.
- A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1. A=8'hAA, B=8'h55, Cin=1 -> S=8'h00, Cout=1.
- A=8'h00, B=8'h00, Cin=1 -> S=8'h01, Cout=0. S and Cout stay stable for 20 idle cycles after done.
- Start accepted with A=8'h12, B=8'h34. Mid-RUN, pulse start with A=8'hFF, B=8'hFF. Required: result S=8'h46, Cout=0, and only one done pulse.
- Assert start in the DONE cycle with new operands A=8'h80, B=8'h80, Cin=0. Required:
  - the next cycle has busy=1;
  - the second done follows 9 cycles after the first;
  - S=8'h00, Cout=1.
- Assert rst on the 4th RUN cycle of A=8'hF0, B=8'h0F. Required:
  - the next cycle shows busy=0, done=0, S=0, Cout=0;
  - no done pulse follows;
  - a new start then completes normally.
